// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel pulse generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {EM_OFF, EM_RISE, EM_FALL, EM_BOTH} edge_mode_e;

  typedef enum logic {ST_IDLE, ST_PULSE} state_e;

  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One channel: edge detector, pulse FSM with down-counter, dropped-edge flag.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x,
  input  logic          en,
  input  logic          primed,
  input  edge_mode_e    mode,
  input  logic [CW-1:0] pulse_len,
  input  logic          retrig,
  output logic          y,
  output logic          miss
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_x_q, y_q, y_d, miss_q, miss_d;
  logic          sel_s, hit_s;
  logic [CW-1:0] len_m1_s;

  assign len_m1_s = CW'(eff_len(32'(pulse_len)) - 32'd1);
  assign hit_s    = en & primed & sel_s;

  // Edge selection against the previous sample.
  always_comb begin
    sel_s = 1'b0;
    case (mode)
      EM_RISE: sel_s = ~prev_x_q & x;
      EM_FALL: sel_s = prev_x_q & ~x;
      EM_BOTH: sel_s = prev_x_q ^ x;
      default: sel_s = 1'b0;
    endcase
  end

  // Pulse FSM: a hit on the last count cycle is a fresh trigger, not a drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    miss_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_PULSE;
          cnt_d   = len_m1_s;
          y_d     = 1'b1;
        end else begin
          y_d     = 1'b0;
        end
      end
      ST_PULSE: begin
        if (hit_s && (retrig || (cnt_q == '0))) begin
          cnt_d = len_m1_s;
          y_d   = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d  = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          miss_d = hit_s;
          y_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
          y_d     = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        y_d     = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      y_q      <= 1'b0;
      miss_q   <= 1'b0;
      prev_x_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      miss_q   <= miss_d;
      prev_x_q <= x;
    end
  end

  assign y    = y_q;
  assign miss = miss_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// CH-channel edge-triggered pulse generator. Define PG_SYNC_EN to add a
// 2-flop input synchronizer (adds 2 cycles latency and 2 priming edges).
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int CH = 4,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [CH-1:0]   x,
  input  logic [2*CH-1:0] mode,
  input  logic [CW-1:0]   pulse_len,
  input  logic            retrig,
  output logic [CH-1:0]   y,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   miss
);

  logic [CH-1:0] x_det_s;
  logic [1:0]    prime_q;
  logic          primed_s;

`ifdef PG_SYNC_EN
  localparam logic [1:0] PRIME_N = 2'd3;
  logic [CH-1:0] x_s1_q, x_s2_q;

  // Two-stage synchronizer for asynchronous channel inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_s1_q <= '0;
      x_s2_q <= '0;
    end else begin
      x_s1_q <= x;
      x_s2_q <= x_s1_q;
    end
  end

  assign x_det_s = x_s2_q;
`else
  localparam logic [1:0] PRIME_N = 2'd1;
  assign x_det_s = x;
`endif

  assign primed_s = (prime_q == PRIME_N);

  // Priming counter: holds off detection until prev_x carries real samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prime_q <= 2'd0;
    end else if (!primed_s) begin
      prime_q <= prime_q + 2'd1;
    end else begin
      prime_q <= prime_q;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pulse_gen_channel #(.CW(CW)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .x         (x_det_s[i]),
      .en        (en),
      .primed    (primed_s),
      .mode      (edge_mode_e'(mode[2*i +: 2])),
      .pulse_len (pulse_len),
      .retrig    (retrig),
      .y         (y[i]),
      .miss      (miss[i])
    );
  end

  assign busy = y;

endmodule
